// File: rtl/accel_stream_pkg.sv
// Shared definitions for the accelerator stream stages: FSM state type,
// trailer field offset helpers and the folded XOR checksum function.
package accel_stream_pkg;

    // Stream-stage state: forwarding data beats, or emitting the trailer.
    typedef enum logic [0:0] {
        PASS    = 1'b0,
        TRAILER = 1'b1
    } state_t;

    // Widest stream the fold helper handles.
    localparam int MAX_DATA_WIDTH = 1024;

    // Trailer layout: count in the upper half, checksum in the lower half.
    function automatic int cnt_lsb(input int dw);
        return dw / 2;
    endfunction

    function automatic int csum_msb(input int dw);
        return dw / 2 - 1;
    endfunction

    // XOR the upper half of a dw-bit word onto its lower half.
    // The word is passed zero-extended to MAX_DATA_WIDTH; bits above dw/2
    // of the result are zero.
    function automatic logic [MAX_DATA_WIDTH/2-1:0] fold_xor(
        input logic [MAX_DATA_WIDTH-1:0] acc,
        input int                        dw
    );
        logic [MAX_DATA_WIDTH/2-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_DATA_WIDTH / 2; i++) begin
            if (i < dw / 2) r[i] = acc[i] ^ acc[i + dw / 2];
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single AXI-stream output register stage. A new beat is loaded whenever the
// register is empty or its current beat is being taken; otherwise data and
// last hold, so the downstream sees a stable beat during stalls.
module axis_out_reg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_last,
    output logic                  load_en,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_ready
);

    assign load_en = !out_valid || out_ready;

    // Output register: load on load_en, hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (load_en) begin
            out_valid <= in_valid;
            out_last  <= in_valid && in_last;
            if (in_valid) out_data <= in_data;
        end
    end

endmodule

// File: rtl/axis_checksum_trailer.sv
// Forwards every input beat and appends one trailer beat per packet holding
// {beat count, folded XOR checksum}. The beat count saturates and flags
// len_ovf; pkt_done counts accepted trailers.
// Optional: define ACCEL_CSUM_BYTESWAP_EN to byte-reverse forwarded data beats
// (the trailer and the checksum are unaffected).
module axis_checksum_trailer
    import accel_stream_pkg::*;
#(
    parameter int DATA_WIDTH  = 64,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [COUNT_WIDTH-1:0] pkt_done,
    output logic                   len_ovf,
    input  logic                   clear_ovf
);

    localparam int HALF     = DATA_WIDTH / 2;
    localparam int CNT_LSB  = cnt_lsb(DATA_WIDTH);
    localparam int CSUM_MSB = csum_msb(DATA_WIDTH);

    state_t                  state;
    logic [COUNT_WIDTH-1:0]  cnt;
    logic [DATA_WIDTH-1:0]   acc;
    logic                    load_en;
    logic                    s_hs;
    logic                    trl_take;
    logic                    cnt_sat;
    logic                    in_valid;
    logic                    in_last;
    logic [DATA_WIDTH-1:0]   in_data;
    logic [DATA_WIDTH-1:0]   fwd_data;
    logic [DATA_WIDTH-1:0]   trailer;

    assign s_axis_tready = (state == PASS) && load_en;
    assign s_hs          = s_axis_tvalid && s_axis_tready;
    assign trl_take      = (state == TRAILER) && load_en;
    assign cnt_sat       = &cnt;

    // Trailer is built from the unswapped accumulator.
    assign trailer[DATA_WIDTH-1:CNT_LSB] = HALF'(cnt);
    assign trailer[CSUM_MSB:0]           = HALF'(fold_xor(MAX_DATA_WIDTH'(acc), DATA_WIDTH));

`ifdef ACCEL_CSUM_BYTESWAP_EN
    for (genvar b = 0; b < DATA_WIDTH / 8; b++) begin : g_swap
        assign fwd_data[8*b +: 8] = s_axis_tdata[DATA_WIDTH-8*(b+1) +: 8];
    end
`else
    assign fwd_data = s_axis_tdata;
`endif

    // In TRAILER the output stage always has a beat to load.
    assign in_valid = (state == PASS) ? s_axis_tvalid : 1'b1;
    assign in_data  = (state == PASS) ? fwd_data : trailer;
    assign in_last  = (state == TRAILER);

    axis_out_reg #(.DATA_WIDTH(DATA_WIDTH)) u_out (
        .clk       (clk),
        .rst_n     (aresetn),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .load_en   (load_en),
        .out_valid (m_axis_tvalid),
        .out_data  (m_axis_tdata),
        .out_last  (m_axis_tlast),
        .out_ready (m_axis_tready)
    );

    // Packet FSM with saturating beat count and XOR accumulator.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= PASS;
            cnt   <= '0;
            acc   <= '0;
        end else if (s_hs) begin
            cnt <= cnt_sat ? cnt : cnt + 1'b1;
            acc <= acc ^ s_axis_tdata;
            if (s_axis_tlast) state <= TRAILER;
        end else if (trl_take) begin
            cnt   <= '0;
            acc   <= '0;
            state <= PASS;
        end
    end

    // Sticky overflow flag; a new overflow beats a simultaneous clear.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)             len_ovf <= 1'b0;
        else if (s_hs && cnt_sat) len_ovf <= 1'b1;
        else if (clear_ovf)       len_ovf <= 1'b0;
    end

    // Completed-packet counter, stepped when a trailer is taken downstream.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn)                                        pkt_done <= '0;
        else if (m_axis_tvalid && m_axis_tready && m_axis_tlast) pkt_done <= pkt_done + 1'b1;
    end

endmodule

// File: tb/tb_axis_checksum_trailer.sv
// Directed, table-driven bench for axis_checksum_trailer (COUNT_WIDTH=4 so the
// saturation corner is reachable with short packets).
module tb_axis_checksum_trailer;

    localparam int DW = 64;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_data;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] m_data;
    logic          m_valid, m_ready, m_last;
    logic [CW-1:0] pkt_done;
    logic          len_ovf, clear_ovf;

    always #5 clk = ~clk;

    axis_checksum_trailer #(.DATA_WIDTH(DW), .COUNT_WIDTH(CW)) dut (
        .clk(clk), .aresetn(aresetn),
        .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tlast(s_last),
        .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tlast(m_last),
        .pkt_done(pkt_done), .len_ovf(len_ovf), .clear_ovf(clear_ovf)
    );

    typedef struct {
        int            n;
        logic [DW-1:0] first;
        logic [DW-1:0] step;
        bit            rnd;
        logic [DW-1:0] exp_trl;
        logic          exp_ovf;
    } vec_t;

    typedef struct packed {
        logic          last;
        logic [DW-1:0] data;
    } beat_t;

    vec_t          vecs[8];
    beat_t         outq[$];
    int            checks = 0;
    int            errs   = 0;
    bit            rnd_mode = 1'b0;
    logic [CW-1:0] exp_done;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_beat(input logic [DW-1:0] x);
`ifdef ACCEL_CSUM_BYTESWAP_EN
        return {<<8{x}};
`else
        return x;
`endif
    endfunction

    // Downstream ready: always 1, or coin-flip when rnd_mode is set.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: capture handshakes, check hold-during-stall.
    bit    prev_stall = 1'b0;
    beat_t prev_b;
    always @(negedge clk) begin
        if (!aresetn) prev_stall = 1'b0;
        else begin
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", m_data, prev_b.data);
                chk("stall_last", 64'(m_last), 64'(prev_b.last));
            end
            if (m_valid && m_ready) outq.push_back({m_last, m_data});
            prev_stall = m_valid && !m_ready;
            prev_b     = {m_last, m_data};
        end
    end

    // Drive one beat from a negedge; return at the negedge after acceptance.
    task automatic send_beat(input logic [DW-1:0] d, input logic l, output int stalls);
        stalls  = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        #1;
        while (!s_ready && stalls < 200) begin
            @(negedge clk);
            #1;
            stalls++;
        end
        if (!s_ready) begin
            checks++;
            errs++;
            $display("FAIL send_timeout: s_axis_tready stuck at 0, required 1");
        end
        @(negedge clk);
    endtask

    task automatic send_pkt(input int n, input logic [DW-1:0] first, input logic [DW-1:0] step);
        int st;
        for (int i = 0; i < n; i++) send_beat(first + 64'(i) * step, i == n - 1, st);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic wait_out(input int cnt);
        int t = 0;
        while (outq.size() < cnt && t < 500) begin
            @(negedge clk);
            #2;
            t++;
        end
        if (outq.size() < cnt) begin
            checks++;
            errs++;
            $display("FAIL out_timeout: %0d beats seen, required %0d", outq.size(), cnt);
        end
    endtask

    task automatic check_pkt(input int n, input logic [DW-1:0] first, input logic [DW-1:0] step,
                             input logic [DW-1:0] exp_trl);
        beat_t b;
        wait_out(n + 1);
        for (int i = 0; i < n; i++) begin
            if (outq.size() == 0) return;
            b = outq.pop_front();
            chk("data", b.data, exp_beat(first + 64'(i) * step));
            chk("data_last", 64'(b.last), 64'd0);
        end
        if (outq.size() == 0) return;
        b = outq.pop_front();
        chk("trailer", b.data, exp_trl);
        chk("trailer_last", 64'(b.last), 64'd1);
    endtask

    // Global time bound.
    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, s1, s2, s3;

        vecs[0] = '{4,  64'h1,                  64'h1, 1'b0, 64'h00000004_00000004, 1'b0};
        vecs[1] = '{4,  64'h1,                  64'h1, 1'b1, 64'h00000004_00000004, 1'b0};
        vecs[2] = '{1,  64'hAA,                 64'h0, 1'b0, 64'h00000001_000000AA, 1'b0};
        vecs[3] = '{1,  64'h01020304_05060708,  64'h0, 1'b0, 64'h00000001_0404040C, 1'b0};
        vecs[4] = '{2,  64'h11111111_00000001,  64'h1, 1'b0, 64'h00000002_00000003, 1'b0};
        vecs[5] = '{3,  64'hFFFF0000_0000FFFF,  64'h0, 1'b1, 64'h00000003_FFFFFFFF, 1'b0};
        vecs[6] = '{15, 64'h0,                  64'h1, 1'b0, 64'h0000000F_0000000F, 1'b0};
        vecs[7] = '{17, 64'h1,                  64'h1, 1'b0, 64'h0000000F_00000001, 1'b1};

        aresetn = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; clear_ovf = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", m_data, 64'd0);
        chk("rst_pkt_done", 64'(pkt_done), 64'd0);
        chk("rst_len_ovf", 64'(len_ovf), 64'd0);
        aresetn = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        @(negedge clk);
        exp_done = '0;

        foreach (vecs[k]) begin
            rnd_mode = vecs[k].rnd;
            send_pkt(vecs[k].n, vecs[k].first, vecs[k].step);
            check_pkt(vecs[k].n, vecs[k].first, vecs[k].step, vecs[k].exp_trl);
            rnd_mode = 1'b0;
            @(negedge clk);
            #2;
            exp_done++;
            chk("pkt_done", 64'(pkt_done), 64'(exp_done));
            chk("len_ovf", 64'(len_ovf), 64'(vecs[k].exp_ovf));
        end

        // Back-to-back 2-beat packets with tvalid held high.
        repeat (2) @(negedge clk);
        send_beat(64'h10, 1'b0, s0);
        send_beat(64'h20, 1'b1, s1);
        send_beat(64'h05, 1'b0, s2);
        send_beat(64'h06, 1'b1, s3);
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("b2b_bubble", 64'(s2), 64'd1);
        chk("b2b_no_other_stall", 64'(s1 + s3), 64'd0);
        check_pkt(2, 64'h10, 64'h10, 64'h00000002_00000030);
        check_pkt(2, 64'h05, 64'h01, 64'h00000002_00000003);
        @(negedge clk);
        #2;
        exp_done += 2;
        chk("b2b_pkt_done", 64'(pkt_done), 64'(exp_done));

        // Clear the sticky overflow flag.
        clear_ovf = 1'b1;
        @(negedge clk);
        clear_ovf = 1'b0;
        #1;
        chk("clear_ovf", 64'(len_ovf), 64'd0);

        // Reset in the middle of a packet.
        send_beat(64'h1, 1'b0, s0);
        send_beat(64'h2, 1'b0, s0);
        s_valid = 1'b0;
        #2;
        aresetn = 1'b0;
        #1;
        chk("midrst_m_valid", 64'(m_valid), 64'd0);
        chk("midrst_pkt_done", 64'(pkt_done), 64'd0);
        repeat (2) @(negedge clk);
        #2;
        aresetn = 1'b1;
        outq.delete();
        @(negedge clk);
        send_pkt(1, 64'hAA, 64'h0);
        check_pkt(1, 64'hAA, 64'h0, 64'h00000001_000000AA);
        @(negedge clk);
        #2;
        chk("midrst_after_pkt_done", 64'(pkt_done), 64'd1);
        repeat (3) @(negedge clk);
        chk("no_extra_beats", 64'(outq.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
        $finish;
    end

endmodule
